// File: rtl/decode_stage.sv
// Registered RV32I/RV64I main-decode stage: decodes one instruction per accepted
// beat into control bits, register fields and a sign-extended immediate.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [XLEN-1:0] out_imm,
    output logic            out_reg_write,
    output logic            out_alu_src,
    output logic            out_mem_write,
    output logic            out_mem_read,
    output logic            out_mem_to_reg,
    output logic            out_branch,
    output logic            out_jump,
    output logic [2:0]      out_alu_op,
    output logic            out_illegal,
    output logic            out_ecall,
    output logic            out_ebreak
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32 or 64");
    end

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_type_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    logic        dec_reg_write, dec_alu_src, dec_mem_write, dec_mem_read;
    logic        dec_mem_to_reg, dec_branch, dec_jump;
    logic [2:0]  dec_alu_op;
    logic        dec_illegal, dec_ecall, dec_ebreak;
    imm_type_e   imm_type;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    dec_imm;
    logic        accept;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_alu_op     = 3'b000;
        dec_illegal    = 1'b0;
        dec_ecall      = 1'b0;
        dec_ebreak     = 1'b0;
        imm_type       = IMM_NONE;
        case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b010;
                if (funct7 == 7'b0000001) begin
                    if (ENABLE_M) dec_alu_op = 3'b100;
                    else          dec_illegal = 1'b1;
                end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b011;
                imm_type      = IMM_I;
            end
            OP_LOAD: begin
                dec_alu_src    = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                imm_type       = IMM_I;
            end
            OP_STORE: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                imm_type      = IMM_S;
            end
            OP_BRANCH: begin
                dec_branch  = 1'b1;
                dec_alu_src = 1'b1;
                dec_alu_op  = 3'b001;
                imm_type    = IMM_B;
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
            end
            OP_JAL: begin
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                imm_type      = IMM_J;
            end
            OP_JALR: begin
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                imm_type      = IMM_I;
                if (funct3 != 3'b000) dec_illegal = 1'b1;
            end
            OP_LUI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b101;
                imm_type      = IMM_U;
            end
            OP_AUIPC: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b110;
                imm_type      = IMM_U;
            end
            OP_FENCE: begin
                dec_illegal = 1'b0;
            end
            OP_SYSTEM: begin
                if (in_instr == 32'h0000_0073)      dec_ecall   = 1'b1;
                else if (in_instr == 32'h0010_0073) dec_ebreak  = 1'b1;
                else                                dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) dec_illegal = 1'b1;

        // Traps squash every side-effecting control and the immediate.
        if (dec_illegal || dec_ecall || dec_ebreak) begin
            dec_reg_write = 1'b0;
            dec_mem_write = 1'b0;
            dec_mem_read  = 1'b0;
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
            dec_alu_op    = 3'b000;
            imm_type      = IMM_NONE;
        end
    end

    // Every immediate fits a sign-extended 32-bit form, so widen that to XLEN.
    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            IMM_U: imm32 = {in_instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
        dec_imm = XLEN'(imm32);
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_funct3     <= '0;
            out_funct7b5   <= 1'b0;
            out_imm        <= '0;
            out_reg_write  <= 1'b0;
            out_alu_src    <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_branch     <= 1'b0;
            out_jump       <= 1'b0;
            out_alu_op     <= '0;
            out_illegal    <= 1'b0;
            out_ecall      <= 1'b0;
            out_ebreak     <= 1'b0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (accept)    out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;

            if (accept) begin
                out_pc         <= in_pc;
                out_rd         <= in_instr[11:7];
                out_rs1        <= in_instr[19:15];
                out_rs2        <= in_instr[24:20];
                out_funct3     <= funct3;
                out_funct7b5   <= in_instr[30];
                out_imm        <= dec_imm;
                out_reg_write  <= dec_reg_write;
                out_alu_src    <= dec_alu_src;
                out_mem_write  <= dec_mem_write;
                out_mem_read   <= dec_mem_read;
                out_mem_to_reg <= dec_mem_to_reg;
                out_branch     <= dec_branch;
                out_jump       <= dec_jump;
                out_alu_op     <= dec_alu_op;
                out_illegal    <= dec_illegal;
                out_ecall      <= dec_ecall;
                out_ebreak     <= dec_ebreak;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV64 instance without M and an RV32 instance
// with M share one stimulus stream; a monitor pops expected beats as they retire.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic [63:0] out_imm;
    logic        out_reg_write, out_alu_src, out_mem_write, out_mem_read;
    logic        out_mem_to_reg, out_branch, out_jump;
    logic [2:0]  out_alu_op;
    logic        out_illegal, out_ecall, out_ebreak;

    logic        m_in_ready, m_valid;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [2:0]  m_funct3, m_alu_op;
    logic        m_funct7b5, m_reg_write, m_alu_src, m_mem_write, m_mem_read;
    logic        m_mem_to_reg, m_branch, m_jump, m_illegal, m_ecall, m_ebreak;

    decode_stage #(.XLEN(64), .ENABLE_M(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_imm(out_imm),
        .out_reg_write(out_reg_write), .out_alu_src(out_alu_src),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch), .out_jump(out_jump),
        .out_alu_op(out_alu_op), .out_illegal(out_illegal),
        .out_ecall(out_ecall), .out_ebreak(out_ebreak)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
        .out_valid(m_valid), .out_ready(out_ready), .out_pc(m_pc),
        .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2),
        .out_funct3(m_funct3), .out_funct7b5(m_funct7b5), .out_imm(m_imm),
        .out_reg_write(m_reg_write), .out_alu_src(m_alu_src),
        .out_mem_write(m_mem_write), .out_mem_read(m_mem_read),
        .out_mem_to_reg(m_mem_to_reg), .out_branch(m_branch), .out_jump(m_jump),
        .out_alu_op(m_alu_op), .out_illegal(m_illegal),
        .out_ecall(m_ecall), .out_ebreak(m_ebreak)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [6:0]  ctrl;
        logic [2:0]  alu_op;
        logic [2:0]  trap;
        logic [2:0]  m_alu_op;
        logic        m_ill;
        int          cycle;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic [63:0] pc_next = 64'h1000;
    logic [63:0] held_pc;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] imm,
                                 input logic [6:0] ctrl, input logic [2:0] alu,
                                 input logic [2:0] trap, input logic [2:0] m_alu,
                                 input logic m_ill, input bit lat);
        exp_t e;
        int waited;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_next;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.instr = instr; e.pc = pc_next; e.imm = imm; e.ctrl = ctrl;
            e.alu_op = alu; e.trap = trap; e.m_alu_op = m_alu; e.m_ill = m_ill;
            e.cycle = cycle; e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pc_next  = pc_next + 64'd4;
    endtask

    // Retire a beat whenever downstream takes it; flushed beats are not consumed.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got instr beat pc %h expected none", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pc", out_pc, mon_e.pc);
                checkOutput("rd", 64'(out_rd), 64'(mon_e.instr[11:7]));
                checkOutput("rs1", 64'(out_rs1), 64'(mon_e.instr[19:15]));
                checkOutput("rs2", 64'(out_rs2), 64'(mon_e.instr[24:20]));
                checkOutput("funct3", 64'(out_funct3), 64'(mon_e.instr[14:12]));
                checkOutput("funct7b5", 64'(out_funct7b5), 64'(mon_e.instr[30]));
                checkOutput("imm", out_imm, mon_e.imm);
                checkOutput("ctrl", 64'({out_reg_write, out_alu_src, out_mem_write, out_mem_read,
                                         out_mem_to_reg, out_branch, out_jump}), 64'(mon_e.ctrl));
                checkOutput("alu_op", 64'(out_alu_op), 64'(mon_e.alu_op));
                checkOutput("trap", 64'({out_illegal, out_ecall, out_ebreak}), 64'(mon_e.trap));
                checkOutput("m_valid", 64'(m_valid), 64'd1);
                checkOutput("m_alu_op", 64'(m_alu_op), 64'(mon_e.m_alu_op));
                checkOutput("m_illegal", 64'(m_illegal), 64'(mon_e.m_ill));
                checkOutput("m_imm", 64'(m_imm), 64'(mon_e.imm[31:0]));
                if (mon_e.lat) checkOutput("latency", 64'(cycle), 64'(mon_e.cycle + 1));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_imm", out_imm, 64'd0);
        checkOutput("rst_pc", out_pc, 64'd0);
        checkOutput("rst_fields", 64'({out_rd, out_rs1, out_rs2, out_funct3, out_funct7b5}), 64'd0);
        checkOutput("rst_ctrl", 64'({out_reg_write, out_alu_src, out_mem_write, out_mem_read,
                                     out_mem_to_reg, out_branch, out_jump, out_alu_op}), 64'd0);
        checkOutput("rst_trap", 64'({out_illegal, out_ecall, out_ebreak}), 64'd0);
        rst = 1'b0;

        $display("[TB] streaming addi/add/beq");
        applyStimulus(32'h00500093, 64'd5, 7'b1100000, 3'b011, 3'b000, 3'b011, 1'b0, 1'b1);
        applyStimulus(32'h002081B3, 64'd0, 7'b1000000, 3'b010, 3'b000, 3'b010, 1'b0, 1'b1);
        applyStimulus(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 7'b0100010, 3'b001, 3'b000, 3'b001, 1'b0, 1'b1);

        $display("[TB] back-pressure");
        applyStimulus(32'h0040A103, 64'd4, 7'b1101100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        held_pc   = pc_next - 64'd4;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFE20AC23;
        in_pc     = pc_next;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_imm", out_imm, 64'd4);
            checkOutput("stall_pc", out_pc, held_pc);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 7'b0110000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

        $display("[TB] jumps, upper immediates, traps");
        applyStimulus(32'h008000EF, 64'd8, 7'b1100001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        applyStimulus(32'h000080E7, 64'd0, 7'b1100001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        applyStimulus(32'h000090E7, 64'd0, 7'b0100000, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
        applyStimulus(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 7'b1100000, 3'b101, 3'b000, 3'b101, 1'b0, 1'b1);
        applyStimulus(32'h00001117, 64'h1000, 7'b1100000, 3'b110, 3'b000, 3'b110, 1'b0, 1'b1);
        applyStimulus(32'h0000000F, 64'd0, 7'b0000000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        applyStimulus(32'h00000073, 64'd0, 7'b0000000, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1);
        applyStimulus(32'h00100073, 64'd0, 7'b0000000, 3'b000, 3'b001, 3'b000, 1'b0, 1'b1);
        applyStimulus(32'h00000000, 64'd0, 7'b0000000, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
        applyStimulus(32'h02208033, 64'd0, 7'b0000000, 3'b000, 3'b100, 3'b100, 1'b0, 1'b1);
        applyStimulus(32'h40208033, 64'd0, 7'b1000000, 3'b010, 3'b000, 3'b010, 1'b0, 1'b1);
        applyStimulus(32'h80208033, 64'd0, 7'b0000000, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
        applyStimulus(32'h00002063, 64'd0, 7'b0100000, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
        applyStimulus(32'h00200073, 64'd0, 7'b0000000, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
        applyStimulus(32'h00000001, 64'd0, 7'b0000000, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1);

        $display("[TB] flush while stalled");
        applyStimulus(32'h0040A103, 64'd4, 7'b1101100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFE20AC23;
        in_pc     = pc_next;
        @(negedge clk);
        checkOutput("pre_flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("post_flush_valid", 64'(out_valid), 64'd0);
            checkOutput("post_flush_imm", out_imm, 64'd4);
            checkOutput("post_flush_rd", 64'(out_rd), 64'd2);
        end

        $display("[TB] reset mid-stall");
        @(posedge clk);
        #1;
        applyStimulus(32'h00001117, 64'h1000, 7'b1100000, 3'b110, 3'b000, 3'b110, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("held_before_rst", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_imm", out_imm, 64'd0);
        checkOutput("async_rst_pc", out_pc, 64'd0);
        checkOutput("async_rst_fields", 64'({out_rd, out_rs1, out_rs2, out_funct3, out_funct7b5}), 64'd0);
        checkOutput("async_rst_ctrl", 64'({out_reg_write, out_alu_src, out_mem_write, out_mem_read,
                                           out_mem_to_reg, out_branch, out_jump, out_alu_op}), 64'd0);
        exp_q.delete(exp_q.size() - 1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        applyStimulus(32'h00500093, 64'd5, 7'b1100000, 3'b011, 3'b000, 3'b011, 1'b0, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
